// File: rtl/lcd_timing_ctrl.sv
// lcd_timing_ctrl: pixel clock-enable divider plus H/V timing (sync, data-enable, coordinates)
module lcd_timing_ctrl #(
    parameter int H_ACTIVE    = 800,
    parameter int H_FP        = 40,
    parameter int H_SYNC      = 48,
    parameter int H_BP        = 40,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 13,
    parameter int V_SYNC      = 3,
    parameter int V_BP        = 32,
    parameter int DIV_DEFAULT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [3:0]  cfg_div,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    output logic        pix_ce,
    output logic        frame_start,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic [10:0] x,
    output logic [9:0]  y
);
    localparam logic [10:0] HT1 = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] HA  = 11'(H_ACTIVE);
    localparam logic [10:0] HS0 = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS1 = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  VT1 = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  VA  = 10'(V_ACTIVE);
    localparam logic [9:0]  VS0 = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS1 = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    logic [3:0]  dcnt, div, pend_div;
    logic        pending, ce_n, h_wrap, fs_n;
    logic [10:0] hcnt, h_n;
    logic [9:0]  vcnt, v_n;
    // next counter values; sync/de are registered from these so they stay coherent with x/y
    always_comb begin
        ce_n   = enable && dcnt == div - 4'd1;
        h_wrap = hcnt == HT1;
        h_n    = ce_n ? (h_wrap ? '0 : hcnt + 11'd1) : hcnt;
        v_n    = ce_n && h_wrap ? (vcnt == VT1 ? '0 : vcnt + 10'd1) : vcnt;
        fs_n   = ce_n && h_wrap && vcnt == VT1;
    end
    assign cfg_ready = !pending;
    assign x = hcnt;
    assign y = vcnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            dcnt        <= '0;
            div         <= 4'(DIV_DEFAULT);
            pend_div    <= 4'(DIV_DEFAULT);
            pending     <= 1'b0;
            hcnt        <= HT1;
            vcnt        <= VT1;
            pix_ce      <= 1'b0;
            frame_start <= 1'b0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            de          <= 1'b0;
        end else begin
            dcnt        <= (ce_n || !enable) ? '0 : dcnt + 4'd1;
            pix_ce      <= ce_n;
            frame_start <= fs_n;
            hcnt        <= h_n;
            vcnt        <= v_n;
            hs          <= !(h_n >= HS0 && h_n <= HS1);
            vs          <= !(v_n >= VS0 && v_n <= VS1);
            de          <= h_n < HA && v_n < VA;
            // a pending divider lands on the frame wrap (dcnt is already 0 there) or at once when idle
            if (pending && (fs_n || !enable)) begin
                div     <= pend_div;
                pending <= 1'b0;
            end else if (cfg_valid && !pending) begin
                pend_div <= cfg_div == 4'd0 ? 4'd1 : cfg_div;
                pending  <= 1'b1;
            end
        end
    end
endmodule
